pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches between the datapath stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque control bundle and data bundle across one stage boundary using a valid/ready handshake. It supports stall via backpressure and a synchronous flush that kills in-flight entries. An optional skid buffer registers the upstream ready path.

## Interface
Parameters:
- CTRL_WIDTH, 8, width of the control bundle; the bundle is forced to zero whenever the stage holds no valid entry (bubble).
- DATA_WIDTH, 96, width of the data bundle; never forced, holds last loaded value.

Ports:
- Clock  in  1  rising-edge clock, single clock domain.
- Reset  in  1  asynchronous, active-low reset.
- Flush  in  1  synchronous kill of all held entries.
- In_Valid  in  1  upstream entry present.
- In_Ready  out  1  stage can accept an entry this cycle.
- In_Ctrl  in  CTRL_WIDTH  upstream control bundle.
- In_Data  in  DATA_WIDTH  upstream data bundle.
- Out_Valid  out  1  entry presented downstream.
- Out_Ready  in  1  downstream accepts this cycle.
- Out_Ctrl  out  CTRL_WIDTH  control bundle of the head entry; 0 when Out_Valid=0.
- Out_Data  out  DATA_WIDTH  data bundle of the head entry.
- Occupancy  out  2  number of held entries (0..2; max 1 without skid).

## Operation
- in_fire = In_Valid & In_Ready; out_fire = Out_Valid & Out_Ready.
- Storage: main entry M (drives Out_*), skid entry S (only with the skid macro).
- Transfer rules when Flush=0:
  - M empty: on in_fire, M <= In.
  - M full, out_fire, S empty: M <= In if in_fire, else M becomes empty.
  - M full, no out_fire, S empty, in_fire: S <= In.
  - M full, S full: In_Ready=0; on out_fire, M <= S and S becomes empty.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by Flush.
- Flush=1 has priority over everything else:
  - M and S both become empty at the edge.
  - An in_fire in the same cycle is accepted and discarded.
  - An out_fire in the same cycle still completes downstream.
- Out_Ctrl = M.ctrl when Out_Valid=1, else all zeros. Control bits of a bubble therefore never reach downstream.
- Out_Data is not cleared by Flush or bubbles.

## Timing
- Reset asserted (low):
  - Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0, S empty.
  - In_Ready=0 while Reset is low; In_Ready=1 from the first edge after release.
- Latency: In accepted at edge N appears on Out_* after edge N, i.e. 1 cycle.
- Throughput: 1 entry/cycle sustained while Out_Ready=1.
- With skid:
  - In_Ready = ~S_valid, driven from a flop, with no combinational path from Out_Ready.
  - Backpressure takes effect 1 cycle late; S absorbs the one in-flight entry.
- Without skid: In_Ready = ~M_valid | Out_Ready, a combinational path from Out_Ready.
- Reset mid-operation discards all entries immediately, asynchronously.
- Occupancy is updated at the same edge as the transfer.

## Configuration
- Macro PIPE_STAGE_SKID_EN.
- Defined: S entry present; In_Ready registered; Occupancy ranges 0..2.
- Undefined: S entry and its logic absent; In_Ready combinational as above; Occupancy ranges 0..1, with bit 1 tied to 0.
- Handshake semantics, latency, flush and bubble rules are identical in both builds.

## Test plan
- Reset/bubble: hold Reset low with In_Valid=1, In_Ctrl=8'hFF → In_Ready=0, Out_Valid=0, Out_Ctrl=0, Out_Data=0. Release → In_Ready=1 next cycle.
- Streaming: Out_Ready=1, inject data 1,2,3,4 on consecutive cycles → Out_Data 1,2,3,4 each one cycle later, Out_Valid continuous, Occupancy=1.
- Stall/skid (macro on):
  - Out_Ready=0 while injecting 5,6,7 → Occupancy goes 1 then 2, In_Ready=0 after 6 is held, 7 waits upstream.
  - Out_Ready=1 → outputs 5,6,7 in order.
- Flush:
  - With Occupancy=2, assert Flush together with In_Valid=1, data 9 → next cycle Out_Valid=0, Out_Ctrl=0, Occupancy=0.
  - Data 9 never appears on Out.
- Async reset mid-stream: drop Reset between edges while Occupancy=2 → Out_Valid=0 and Occupancy=0 immediately, without waiting for an edge.
- Macro off: Out_Ready=0 with M full → In_Ready=0 combinationally. Raise Out_Ready → In_Ready=1 in the same cycle and a back-to-back transfer occurs.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-entry pipeline stage register with a valid/ready
// handshake, a synchronous flush and bubble-zeroed control bits.
// Optional skid entry, enabled by defining PIPE_STAGE_SKID_EN, registers
// In_Ready so that no combinational path runs from Out_Ready to In_Ready.
module pipe_stage_reg #(
  parameter int CTRL_WIDTH = 8,
  parameter int DATA_WIDTH = 96
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [CTRL_WIDTH-1:0] In_Ctrl,
  input  logic [DATA_WIDTH-1:0] In_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [CTRL_WIDTH-1:0] Out_Ctrl,
  output logic [DATA_WIDTH-1:0] Out_Data,
  output logic [1:0]            Occupancy
);

  // Main entry: the head of the stage, drives Out_*.
  logic                  m_valid, m_valid_nxt;
  logic [CTRL_WIDTH-1:0] m_ctrl,  m_ctrl_nxt;
  logic [DATA_WIDTH-1:0] m_data,  m_data_nxt;

  logic in_fire;
  logic out_fire;

  assign in_fire  = In_Valid & In_Ready;
  assign out_fire = m_valid & Out_Ready;

  // Bubbles present all-zero control so stale bits never reach downstream.
  assign Out_Valid = m_valid;
  assign Out_Ctrl  = m_valid ? m_ctrl : '0;
  assign Out_Data  = m_data;

`ifdef PIPE_STAGE_SKID_EN

  // Skid entry: holds the single entry that arrives during the cycle in
  // which backpressure is still propagating through the registered ready.
  logic                  s_valid, s_valid_nxt;
  logic [CTRL_WIDTH-1:0] s_ctrl,  s_ctrl_nxt;
  logic [DATA_WIDTH-1:0] s_data,  s_data_nxt;
  logic                  ready_q;

  assign In_Ready  = ready_q;
  assign Occupancy = {m_valid & s_valid, m_valid ^ s_valid};

  // Next-state for both entries; flush overrides every transfer.
  always_comb begin
    // NOTE: every output of this block gets a default first, otherwise a
    // path that leaves one unassigned infers a latch.
    m_valid_nxt = m_valid;
    m_ctrl_nxt  = m_ctrl;
    m_data_nxt  = m_data;
    s_valid_nxt = s_valid;
    s_ctrl_nxt  = s_ctrl;
    s_data_nxt  = s_data;
    if (Flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else if (!m_valid) begin
      if (in_fire) begin
        m_valid_nxt = 1'b1;
        m_ctrl_nxt  = In_Ctrl;
        m_data_nxt  = In_Data;
      end
    end else if (!s_valid) begin
      if (out_fire) begin
        m_valid_nxt = in_fire;
        if (in_fire) begin
          m_ctrl_nxt = In_Ctrl;
          m_data_nxt = In_Data;
        end
      end else if (in_fire) begin
        s_valid_nxt = 1'b1;
        s_ctrl_nxt  = In_Ctrl;
        s_data_nxt  = In_Data;
      end
    end else if (out_fire) begin
      m_ctrl_nxt  = s_ctrl;
      m_data_nxt  = s_data;
      s_valid_nxt = 1'b0;
    end
  end

  // Valid flags, main entry and registered ready; ready stays low in reset.
  always_ff @(posedge Clock or negedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!Reset) begin
      m_valid <= 1'b0;
      m_ctrl  <= '0;
      m_data  <= '0;
      s_valid <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      m_valid <= m_valid_nxt;
      m_ctrl  <= m_ctrl_nxt;
      m_data  <= m_data_nxt;
      s_valid <= s_valid_nxt;
      ready_q <= ~s_valid_nxt;
    end
  end

  // Skid payload: qualified by s_valid, so it needs no reset.
  always_ff @(posedge Clock) begin
    // NOTE: payload-only storage is left unreset; its valid flag guards it
    // and the reset fan-out stays on the control flops.
    s_ctrl <= s_ctrl_nxt;
    s_data <= s_data_nxt;
  end

`else

  // Gates In_Ready low until the first edge after reset release.
  logic ready_en;

  assign In_Ready  = ready_en & (~m_valid | Out_Ready);
  assign Occupancy = {1'b0, m_valid};

  // Next-state for the single entry; flush overrides every transfer.
  always_comb begin
    m_valid_nxt = m_valid;
    m_ctrl_nxt  = m_ctrl;
    m_data_nxt  = m_data;
    if (Flush) begin
      m_valid_nxt = 1'b0;
    end else if (!m_valid || out_fire) begin
      m_valid_nxt = in_fire;
      if (in_fire) begin
        m_ctrl_nxt = In_Ctrl;
        m_data_nxt = In_Data;
      end
    end
  end

  // Main entry and the post-reset ready enable.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      m_valid  <= 1'b0;
      m_ctrl   <= '0;
      m_data   <= '0;
      ready_en <= 1'b0;
    end else begin
      m_valid  <= m_valid_nxt;
      m_ctrl   <= m_ctrl_nxt;
      m_data   <= m_data_nxt;
      ready_en <= 1'b1;
    end
  end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg
// against a queue-based model of the stage (capacity 2 with the skid
// entry, 1 without).
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAPACITY = 2;
  localparam bit SKID     = 1'b1;
`else
  localparam int CAPACITY = 1;
  localparam bit SKID     = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  In_Ctrl;
  logic [95:0] In_Data;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [7:0]  Out_Ctrl;
  logic [95:0] Out_Data;
  logic [1:0]  Occupancy;

  pipe_stage_reg #(.CTRL_WIDTH(8), .DATA_WIDTH(96)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Flush     (Flush),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .In_Ctrl   (In_Ctrl),
    .In_Data   (In_Data),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Out_Ctrl  (Out_Ctrl),
    .Out_Data  (Out_Data),
    .Occupancy (Occupancy)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]  ctrl;
    logic [95:0] data;
  } entry_t;

  // Reference model state.
  entry_t      q[$];
  bit          ready_ok;
  logic [95:0] last_data;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    ready_ok  = 1'b0;
    last_data = '0;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // then advance the model past the rising edge.
  task automatic step(input logic v, input logic [7:0] c, input logic [95:0] d,
                      input logic ordy, input logic fl);
    bit     exp_rdy, in_f, out_f;
    entry_t e;
    In_Valid  = v;
    In_Ctrl   = c;
    In_Data   = d;
    Out_Ready = ordy;
    Flush     = fl;
    @(negedge Clock);
    exp_rdy = ready_ok && (SKID ? (q.size() < CAPACITY) : (q.size() == 0 || ordy));
    check("in_ready",  In_Ready,  exp_rdy);
    check("out_valid", Out_Valid, q.size() > 0);
    check("out_ctrl",  Out_Ctrl,  (q.size() > 0) ? q[0].ctrl : 8'h00);
    check("out_data",  Out_Data,  (q.size() > 0) ? q[0].data : last_data);
    check("occupancy", Occupancy, q.size());
    in_f  = v && exp_rdy;
    out_f = (q.size() > 0) && ordy;
    @(posedge Clock);
    #1;
    if (Reset) begin
      if (out_f) void'(q.pop_front());
      if (in_f) begin
        e.ctrl = c;
        e.data = d;
        q.push_back(e);
      end
      if (fl) q.delete();
      ready_ok = 1'b1;
      if (q.size() > 0) last_data = q[0].data;
    end
  endtask

  function automatic logic [95:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    Reset     = 1'b0;
    Flush     = 1'b0;
    In_Valid  = 1'b1;
    In_Ctrl   = 8'hFF;
    In_Data   = '1;
    Out_Ready = 1'b1;
    model_reset();

    // Reset held with an upstream entry present.
    step(1'b1, 8'hFF, '1, 1'b1, 1'b0);
    step(1'b1, 8'hFF, '1, 1'b1, 1'b0);
    Reset = 1'b1;
    step(1'b1, 8'hFF, 96'h0, 1'b1, 1'b0);

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i + 8'h10), 96'(i), 1'b1, 1'b0);
    step(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);

    // Stall with 5,6,7, then drain.
    for (int i = 5; i <= 7; i++) step(1'b1, 8'(i + 8'h20), 96'(i), 1'b0, 1'b0);
    step(1'b1, 8'h27, 96'h7, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h27, 96'h7, 1'b1, 1'b0);
    step(1'b0, 8'h00, 96'h0, 1'b1, 1'b0);

    // Fill, then flush while offering data 9.
    step(1'b1, 8'h31, 96'hA1, 1'b0, 1'b0);
    step(1'b1, 8'h32, 96'hA2, 1'b0, 1'b0);
    step(1'b1, 8'h39, 96'h9,  1'b0, 1'b1);
    step(1'b0, 8'h00, 96'h0,  1'b1, 1'b0);
    step(1'b0, 8'h00, 96'h0,  1'b1, 1'b0);

`ifndef PIPE_STAGE_SKID_EN
    // Combinational ready: stalled with M full, then released mid-cycle.
    step(1'b1, 8'h41, 96'hB1, 1'b0, 1'b0);
    In_Valid  = 1'b1;
    Out_Ready = 1'b0;
    #2;
    check("comb_ready_low", In_Ready, 1'b0);
    step(1'b1, 8'h42, 96'hB2, 1'b1, 1'b0);
    step(1'b0, 8'h00, 96'h0,  1'b1, 1'b0);
`endif

    // Asynchronous reset between edges with the stage full.
    step(1'b1, 8'h51, 96'hC1, 1'b0, 1'b0);
    step(1'b1, 8'h52, 96'hC2, 1'b0, 1'b0);
    #3;
    Reset = 1'b0;
    #1;
    check("arst_out_valid", Out_Valid, 1'b0);
    check("arst_occupancy", Occupancy, 2'd0);
    check("arst_out_ctrl",  Out_Ctrl,  8'h00);
    check("arst_in_ready",  In_Ready,  1'b0);
    model_reset();
    @(posedge Clock);
    #1;
    step(1'b1, 8'h5F, 96'h5F, 1'b1, 1'b0);
    Reset = 1'b1;
    step(1'b1, 8'h60, 96'h60, 1'b1, 1'b0);

    // Randomized phases: varied downstream readiness and flush rate.
    for (int ph = 0; ph < 3; ph++) begin
      for (int i = 0; i < 400; i++) begin
        logic ordy;
        case (ph)
          0:       ordy = 1'b1;
          1:       ordy = ($urandom_range(3) != 0);
          default: ordy = ($urandom_range(3) == 0);
        endcase
        step($urandom_range(1) == 1, 8'($urandom), rnd_data(), ordy,
             $urandom_range(15) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
